// File: rtl/operand_sequencer.sv
// operand_sequencer
//  Collects decoded key events from input_control (KeyRdy/KeyRd handshake)
//  into signed decimal operands, an operator and an equals request for the
//  downstream ALU. Holds the value to display (entry or last result) and
//  supports chaining further operations onto a result.
//
// Ports
//  Clock, Reset             system clock, synchronous active-high reset
//  KeyRdy / KeyRd           key event pending / one-cycle consume pulse
//  Number, Operator,        event payload: digit, operator code, equals key
//  EqualSign
//  CalcReq / CalcAck        calculation request held until ALU acknowledges
//  ResultIn, ResultOvf      ALU result and overflow, valid with CalcAck
//  OperandA, OperandB,      operands and latched operator for the ALU
//  OpCode
//  DisplayValue             current entry or last result
//  EntryErr, ResultErr      digit rejected by limit / captured ALU overflow
//
// state   | meaning
// ENTER_A | editing left operand
// ENTER_B | operator latched, editing right operand
// CALC    | request outstanding, waiting for CalcAck; keys held off
// SHOW    | result in OperandA displayed, ready to chain or start over

module operand_sequencer #(
   parameter int WIDTH   = 16,
   parameter int MAX_MAG = 2**(WIDTH-1)-1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             KeyRdy,
   output logic             KeyRd,
   input  logic [3:0]       Number,
   input  logic [2:0]       Operator,
   input  logic             EqualSign,
   output logic             CalcReq,
   input  logic             CalcAck,
   input  logic [WIDTH-1:0] ResultIn,
   input  logic             ResultOvf,
   output logic [WIDTH-1:0] OperandA,
   output logic [WIDTH-1:0] OperandB,
   output logic [2:0]       OpCode,
   output logic [WIDTH-1:0] DisplayValue,
   output logic             EntryErr,
   output logic             ResultErr
);

   typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_t;

   localparam logic [2:0] OP_SIGN = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_CLR  = 3'b110;

   localparam logic [WIDTH+3:0] TEN      = (WIDTH+4)'(10);
   localparam logic [WIDTH+3:0] MAX_EXT  = (WIDTH+4)'(MAX_MAG);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-2:0] mag_q, mag_d;
   logic             neg_q, neg_d;
   logic             armed_q, armed_d;
   logic             keyrd_d, calcreq_d, entry_err_d, result_err_d;
   logic [WIDTH-1:0] opa_d, opb_d, display_d;
   logic [2:0]       opcode_d;

   logic             consume, ev_eq, ev_op, ev_dig, is_arith;
   logic [WIDTH+3:0] digit_sum;

   function automatic logic [WIDTH-1:0] entry_value(input logic [WIDTH-2:0] m, input logic n);
      logic [WIDTH-1:0] e;
      e = {1'b0, m};
      return n ? -e : e;
   endfunction

   // Event class priority: equals, then any operator, then digit.
   assign ev_eq    = EqualSign;
   assign ev_op    = !EqualSign && (Operator != 3'b000);
   assign ev_dig   = !EqualSign && (Operator == 3'b000) && (Number <= 4'd9);
   assign is_arith = (Operator == OP_ADD) || (Operator == OP_SUB) || (Operator == OP_MUL);
   assign consume  = (state_q != CALC) && KeyRdy && armed_q;
   // Wide enough that mag*10+9 can never wrap before the limit compare.
   assign digit_sum = (WIDTH+4)'(mag_q) * TEN + (WIDTH+4)'(Number);

   always_comb begin
      state_d      = state_q;
      mag_d        = mag_q;
      neg_d        = neg_q;
      armed_d      = armed_q;
      keyrd_d      = 1'b0;
      calcreq_d    = CalcReq;
      opa_d        = OperandA;
      opb_d        = OperandB;
      opcode_d     = OpCode;
      entry_err_d  = EntryErr;
      result_err_d = ResultErr;

      if (!KeyRdy)
         armed_d = 1'b1;

      if (consume) begin
         armed_d = 1'b0;
         keyrd_d = 1'b1;
         if (ev_op && (Operator == OP_CLR)) begin
            state_d      = ENTER_A;
            mag_d        = '0;
            neg_d        = 1'b0;
            calcreq_d    = 1'b0;
            opa_d        = '0;
            opb_d        = '0;
            opcode_d     = 3'b000;
            entry_err_d  = 1'b0;
            result_err_d = 1'b0;
         end else begin
            case (state_q)
               ENTER_A, ENTER_B: begin
                  if (ev_dig) begin
                     if (digit_sum > MAX_EXT)
                        entry_err_d = 1'b1;
                     else
                        mag_d = digit_sum[WIDTH-2:0];
                  end else if (ev_op && (Operator == OP_SIGN)) begin
                     neg_d = !neg_q;
                  end else if (ev_op && is_arith) begin
                     opcode_d = Operator;
                     if (state_q == ENTER_A) begin
                        opa_d       = entry_value(mag_q, neg_q);
                        mag_d       = '0;
                        neg_d       = 1'b0;
                        entry_err_d = 1'b0;
                        state_d     = ENTER_B;
                     end
                  end else if (ev_eq && (state_q == ENTER_B)) begin
                     opb_d     = entry_value(mag_q, neg_q);
                     calcreq_d = 1'b1;
                     state_d   = CALC;
                  end
               end
               SHOW: begin
                  if (ev_dig) begin
                     mag_d        = (WIDTH-1)'(Number);
                     neg_d        = 1'b0;
                     entry_err_d  = 1'b0;
                     result_err_d = 1'b0;
                     state_d      = ENTER_A;
                  end else if (ev_op && (Operator == OP_SIGN)) begin
                     // The most negative value has no positive counterpart.
                     if (OperandA == MOST_NEG)
                        entry_err_d = 1'b1;
                     else
                        opa_d = -OperandA;
                  end else if (ev_op && is_arith) begin
                     opcode_d = Operator;
                     state_d  = ENTER_B;
                  end else if (ev_eq) begin
                     calcreq_d = 1'b1;
                     state_d   = CALC;
                  end
               end
               default: ;
            endcase
         end
      end else if ((state_q == CALC) && CalcAck) begin
         calcreq_d    = 1'b0;
         opa_d        = ResultIn;
         result_err_d = ResultOvf;
         mag_d        = '0;
         neg_d        = 1'b0;
         entry_err_d  = 1'b0;
         state_d      = SHOW;
      end

      display_d = ((state_d == ENTER_A) || (state_d == ENTER_B)) ? entry_value(mag_d, neg_d) : opa_d;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= ENTER_A;
         mag_q        <= '0;
         neg_q        <= 1'b0;
         armed_q      <= 1'b1;
         KeyRd        <= 1'b0;
         CalcReq      <= 1'b0;
         OperandA     <= '0;
         OperandB     <= '0;
         OpCode       <= 3'b000;
         DisplayValue <= '0;
         EntryErr     <= 1'b0;
         ResultErr    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mag_q        <= mag_d;
         neg_q        <= neg_d;
         armed_q      <= armed_d;
         KeyRd        <= keyrd_d;
         CalcReq      <= calcreq_d;
         OperandA     <= opa_d;
         OperandB     <= opb_d;
         OpCode       <= opcode_d;
         DisplayValue <= display_d;
         EntryErr     <= entry_err_d;
         ResultErr    <= result_err_d;
      end
   end

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        KeyRdy = 1'b0;
   logic        KeyRd;
   logic [3:0]  Number = 4'd0;
   logic [2:0]  Operator = 3'b000;
   logic        EqualSign = 1'b0;
   logic        CalcReq;
   logic        CalcAck = 1'b0;
   logic [15:0] ResultIn = 16'd0;
   logic        ResultOvf = 1'b0;
   logic [15:0] OperandA, OperandB, DisplayValue;
   logic [2:0]  OpCode;
   logic        EntryErr, ResultErr;

   always #5 Clock = ~Clock;

   operand_sequencer dut (
      .Clock(Clock), .Reset(Reset), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
      .Number(Number), .Operator(Operator), .EqualSign(EqualSign),
      .CalcReq(CalcReq), .CalcAck(CalcAck), .ResultIn(ResultIn), .ResultOvf(ResultOvf),
      .OperandA(OperandA), .OperandB(OperandB), .OpCode(OpCode),
      .DisplayValue(DisplayValue), .EntryErr(EntryErr), .ResultErr(ResultErr)
   );

   typedef struct { logic [3:0] num; logic [2:0] op; logic eq; } key_t;
   typedef struct { logic [15:0] disp; logic eerr; logic rerr; logic creq; } obs_t;
   typedef struct { logic [15:0] a; logic [15:0] b; logic [2:0] op; } req_t;

   obs_t key_q[$];
   obs_t ack_q[$];
   req_t req_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;

   // Reference model: plain integers for the entry and operands.
   typedef enum {M_A, M_B, M_CALC, M_SHOW} mphase_t;
   mphase_t    m_phase = M_A;
   int         m_mag = 0, m_a = 0, m_b = 0;
   bit         m_neg = 0, m_eerr = 0, m_rerr = 0;
   logic [2:0] m_op = 3'b000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ent();
      return m_neg ? -m_mag : m_mag;
   endfunction

   function automatic obs_t expect_now();
      obs_t o;
      o.disp = (m_phase == M_A || m_phase == M_B) ? 16'(ent()) : 16'(m_a);
      o.eerr = m_eerr;
      o.rerr = m_rerr;
      o.creq = (m_phase == M_CALC);
      return o;
   endfunction

   function automatic key_t mk(input int num, input logic [2:0] op, input logic eq);
      key_t k;
      k.num = 4'(num);
      k.op  = op;
      k.eq  = eq;
      return k;
   endfunction

   function automatic key_t kd(input int d);
      return mk(d, 3'b000, 1'b0);
   endfunction

   task automatic model_clear();
      m_phase = M_A; m_mag = 0; m_neg = 0; m_a = 0; m_b = 0;
      m_op = 3'b000; m_eerr = 0; m_rerr = 0;
   endtask

   task automatic model_key(input key_t k);
      bit is_eq, is_op, is_dig, arith;
      int nxt;
      req_t r;
      is_eq  = k.eq;
      is_op  = !k.eq && k.op != 3'b000;
      is_dig = !is_eq && !is_op && k.num <= 9;
      arith  = k.op == 3'b010 || k.op == 3'b011 || k.op == 3'b100;
      if (is_op && k.op == 3'b110) begin
         model_clear();
      end else if (m_phase == M_A || m_phase == M_B) begin
         if (is_dig) begin
            nxt = m_mag * 10 + int'(k.num);
            if (nxt > 32767) m_eerr = 1;
            else m_mag = nxt;
         end else if (is_op && k.op == 3'b001) begin
            m_neg = !m_neg;
         end else if (is_op && arith) begin
            m_op = k.op;
            if (m_phase == M_A) begin
               m_a = ent(); m_mag = 0; m_neg = 0; m_eerr = 0; m_phase = M_B;
            end
         end else if (is_eq && m_phase == M_B) begin
            m_b = ent();
            m_phase = M_CALC;
            r.a = 16'(m_a); r.b = 16'(m_b); r.op = m_op;
            req_q.push_back(r);
         end
      end else if (m_phase == M_SHOW) begin
         if (is_dig) begin
            m_mag = int'(k.num); m_neg = 0; m_eerr = 0; m_rerr = 0; m_phase = M_A;
         end else if (is_op && k.op == 3'b001) begin
            if (m_a == -32768) m_eerr = 1;
            else m_a = -m_a;
         end else if (is_op && arith) begin
            m_op = k.op; m_phase = M_B;
         end else if (is_eq) begin
            m_phase = M_CALC;
            r.a = 16'(m_a); r.b = 16'(m_b); r.op = m_op;
            req_q.push_back(r);
         end
      end
      key_q.push_back(expect_now());
   endtask

   task automatic model_ack(input logic [15:0] res, input logic ovf);
      m_a = int'($signed(res));
      m_rerr = ovf; m_mag = 0; m_neg = 0; m_eerr = 0;
      m_phase = M_SHOW;
      ack_q.push_back(expect_now());
   endtask

   task automatic drive_key(input key_t k);
      Number = k.num; Operator = k.op; EqualSign = k.eq;
   endtask

   task automatic wait_keyrd();
      for (int i = 0; i < 20; i++) begin
         @(posedge Clock); #1;
         if (KeyRd) break;
      end
      check("keyrd_seen", KeyRd, 1);
   endtask

   task automatic press(input key_t k);
      model_key(k);
      drive_key(k);
      KeyRdy = 1'b1;
      wait_keyrd();
      KeyRdy = 1'b0;
      @(posedge Clock); #1;
   endtask

   task automatic do_ack(input logic [15:0] res, input logic ovf);
      check("calcreq_held", CalcReq, 1);
      model_ack(res, ovf);
      ResultIn = res; ResultOvf = ovf; CalcAck = 1'b1;
      @(posedge Clock); #1;
      CalcAck = 1'b0; ResultIn = 16'($urandom); ResultOvf = 1'($urandom);
   endtask

   function automatic key_t rand_key();
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) return kd($urandom_range(0, 9));
      if (r < 58) return kd($urandom_range(10, 15));
      if (r < 60) return mk($urandom_range(0, 15), ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b111, 1'b0);
      if (r < 68) return mk(0, 3'b001, 1'b0);
      if (r < 76) return mk(0, 3'b010, 1'b0);
      if (r < 82) return mk(0, 3'b011, 1'b0);
      if (r < 88) return mk(0, 3'b100, 1'b0);
      if (r < 97) return mk($urandom_range(0, 15), 3'($urandom_range(0, 7)), 1'b1);
      return mk(0, 3'b110, 1'b0);
   endfunction

   // Monitor: pops an expectation whenever the DUT presents a consumed key,
   // a new calculation request, or the cycle after an accepted acknowledge.
   bit   creq_prev = 0;
   bit   ack_pend  = 0;
   obs_t e;
   req_t rq;

   task automatic compare_obs(input string tag, input obs_t x);
      check({tag, "_display"}, DisplayValue, x.disp);
      check({tag, "_entry_err"}, EntryErr, x.eerr);
      check({tag, "_result_err"}, ResultErr, x.rerr);
      check({tag, "_calc_req"}, CalcReq, x.creq);
   endtask

   always @(negedge Clock) begin
      if (!mon_en || Reset) begin
         creq_prev = 0;
         ack_pend  = 0;
      end else begin
         if (ack_pend) begin
            ack_pend = 0;
            if (ack_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_ack: no result queued at %0t", $time);
            end else begin
               e = ack_q.pop_front();
               compare_obs("ack", e);
            end
         end
         if (CalcReq && CalcAck) ack_pend = 1;
         if (KeyRd) begin
            if (key_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_keyrd: no key queued at %0t", $time);
            end else begin
               e = key_q.pop_front();
               compare_obs("key", e);
            end
         end
         if (CalcReq && !creq_prev) begin
            if (req_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_calcreq: no request queued at %0t", $time);
            end else begin
               rq = req_q.pop_front();
               check("req_operand_a", OperandA, rq.a);
               check("req_operand_b", OperandB, rq.b);
               check("req_opcode", OpCode, rq.op);
            end
         end
         creq_prev = CalcReq;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      key_t k;
      repeat (3) @(posedge Clock);
      #1;
      check("rst_keyrd", KeyRd, 0);
      check("rst_calcreq", CalcReq, 0);
      check("rst_operand_a", OperandA, 0);
      check("rst_operand_b", OperandB, 0);
      check("rst_opcode", OpCode, 0);
      check("rst_display", DisplayValue, 0);
      check("rst_errs", {EntryErr, ResultErr}, 0);
      Reset = 1'b0;
      mon_en = 1'b1;
      model_clear();
      @(posedge Clock); #1;

      // 1,2,3,A,4,5,C then result 168
      press(kd(1)); press(kd(2)); press(kd(3)); press(mk(0, 3'b010, 0));
      press(kd(4)); press(kd(5)); press(mk(0, 3'b000, 1));
      check("t1_operand_a", OperandA, 123);
      check("t1_opcode", OpCode, 3'b010);
      check("t1_operand_b", OperandB, 45);
      do_ack(16'd168, 1'b0);
      check("t1_display", DisplayValue, 168);
      check("t1_calcreq_low", CalcReq, 0);

      // magnitude limit
      press(kd(3)); press(kd(2)); press(kd(7)); press(kd(6)); press(kd(7));
      check("t2_display_max", DisplayValue, 32767);
      check("t2_no_err", EntryErr, 0);
      press(kd(8));
      check("t2_display_kept", DisplayValue, 32767);
      check("t2_err", EntryErr, 1);
      press(mk(0, 3'b110, 0));

      // 5,#,B,3,C
      press(kd(5)); press(mk(0, 3'b001, 0)); press(mk(0, 3'b011, 0));
      press(kd(3)); press(mk(0, 3'b000, 1));
      check("t3_operand_a", OperandA, 16'hFFFB);
      check("t3_opcode", OpCode, 3'b011);
      check("t3_operand_b", OperandB, 3);

      // key raised while in CALC is held off until after the ack
      k = mk(0, 3'b100, 0);
      model_ack(16'd168, 1'b0);
      model_key(k);
      drive_key(k);
      KeyRdy = 1'b1;
      cnt = 0;
      repeat (4) begin
         @(posedge Clock); #1;
         if (KeyRd) cnt++;
      end
      check("t5_keyrd_blocked", cnt, 0);
      ResultIn = 16'd168; ResultOvf = 1'b0; CalcAck = 1'b1;
      @(posedge Clock); #1;
      CalcAck = 1'b0;
      check("t5_keyrd_ack_cycle", KeyRd, 0);
      wait_keyrd();
      KeyRdy = 1'b0;
      @(posedge Clock); #1;
      press(kd(2)); press(mk(0, 3'b000, 1));
      check("t5_operand_a", OperandA, 168);
      check("t5_opcode", OpCode, 3'b100);
      check("t5_operand_b", OperandB, 2);
      do_ack(16'd336, 1'b1);
      check("t5_result_err", ResultErr, 1);

      // KeyRdy held high: exactly one pulse
      k = kd(9);
      model_key(k);
      drive_key(k);
      KeyRdy = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(posedge Clock); #1;
         if (KeyRd) cnt++;
      end
      check("t4_one_pulse", cnt, 1);
      KeyRdy = 1'b0;
      @(posedge Clock); #1;
      press(kd(1));
      check("t4_second_key", DisplayValue, 91);

      // clear mid-ENTER_B
      press(mk(0, 3'b010, 0)); press(kd(4)); press(mk(0, 3'b110, 0));
      check("t6_clear_a", OperandA, 0);
      check("t6_clear_b", OperandB, 0);
      check("t6_clear_op", OpCode, 0);
      check("t6_clear_disp", DisplayValue, 0);
      check("t6_clear_flags", {CalcReq, EntryErr, ResultErr}, 0);

      // reset while CalcReq is high, with a key pending across reset
      press(kd(1)); press(mk(0, 3'b010, 0)); press(kd(2)); press(mk(0, 3'b000, 1));
      check("t6_calcreq_up", CalcReq, 1);
      k = kd(7);
      drive_key(k);
      KeyRdy = 1'b1;
      mon_en = 1'b0;
      Reset = 1'b1;
      @(posedge Clock); #1;
      check("t6_reset_calcreq", CalcReq, 0);
      check("t6_reset_keyrd", KeyRd, 0);
      model_clear();
      model_key(k);
      Reset = 1'b0;
      mon_en = 1'b1;
      wait_keyrd();
      KeyRdy = 1'b0;
      @(posedge Clock); #1;
      check("t6_pending_served", DisplayValue, 7);

      // randomized traffic
      for (int it = 0; it < 400; it++) begin
         if (m_phase == M_CALC) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge Clock); #1;
            end
            do_ack(($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom), 1'($urandom));
         end else if ($urandom_range(0, 19) == 0) begin
            ResultIn = 16'($urandom); CalcAck = 1'b1;
            @(posedge Clock); #1;
            CalcAck = 1'b0;
            check("spurious_ack_ignored", DisplayValue, expect_now().disp);
         end else begin
            press(rand_key());
         end
      end

      repeat (3) begin
         @(posedge Clock); #1;
      end
      check("key_q_drained", key_q.size(), 0);
      check("ack_q_drained", ack_q.size(), 0);
      check("req_q_drained", req_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
